// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the unified-memory arbiter:
//               FSM state encoding, grant encoding, default data width and
//               the saturating run-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int RUN_W         = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Increment that sticks at the ceiling instead of wrapping.
   function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] cur,
                                                    input logic [RUN_W-1:0] max);
      run_sat_inc = (cur >= max) ? max : cur + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_prio.sv
// ============================================================================
// Module      : mem_arb_prio
// Description : Grant selection between fetch and data ports. Data has fixed
//               priority, but after MAX_DATA_RUN back-to-back data grants
//               taken while a fetch was waiting, the fetch is forced through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_prio
   import mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_RUN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arb_en,
   input  logic             instr_req,
   input  logic             data_req,
   output logic             gnt_valid,
   output logic             gnt_sel,
   output logic [RUN_W-1:0] run_cnt
);

   localparam logic [RUN_W-1:0] C_MAX_RUN = RUN_W'(MAX_DATA_RUN);

   logic [RUN_W-1:0] run_d, run_q;
   logic             data_ok;

   // Pick the winner and compute the next run count for this arbitration slot.
   always_comb begin
      data_ok   = data_req && ((run_q < C_MAX_RUN) || !instr_req);
      gnt_valid = arb_en && (data_ok || instr_req);
      gnt_sel   = data_ok ? GNT_D : GNT_I;
      run_d     = run_q;
      if (arb_en) begin
         if (data_ok) begin
            // Only a data grant that overtakes a waiting fetch counts towards the limit.
            run_d = instr_req ? run_sat_inc(run_q, C_MAX_RUN) : '0;
         end else if (instr_req) begin
            run_d = '0;
         end
      end
   end

   // Run counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) run_q <= '0;
      else        run_q <= run_d;
   end

   assign run_cnt = run_q;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-port unified memory between the fetch port
//               and the data port of a pipelined core. One transaction is in
//               flight at a time; stall outputs freeze the pipeline until the
//               owning port's access completes.
//               Optional: define MEM_ARB_PERF_EN to add stall_f_cnt and
//               stall_m_cnt stall-cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WIDTH        = DEFAULT_WIDTH,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrReq,
   input  logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] InstrF,
   output logic             InstrValid,
   input  logic             DataReq,
   input  logic             DataWe,
   input  logic [WIDTH-1:0] DataAdr,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData,
   output logic             DataDone,
   output logic             StallF,
   output logic             StallM,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]      stall_f_cnt,
   output logic [31:0]      stall_m_cnt
`endif
);

   state_e           state_d, state_q;
   logic             gnt_d, gnt_q;
   logic             we_d, we_q;
   logic [WIDTH-1:0] addr_d, addr_q;
   logic [WIDTH-1:0] wdata_d, wdata_q;
   logic [WIDTH-1:0] instr_d, instr_q;
   logic [WIDTH-1:0] rdata_d, rdata_q;
   logic             ivalid_d, ivalid_q;
   logic             ddone_d, ddone_q;

   logic             arb_en;
   logic             gnt_valid;
   logic             gnt_sel;
   logic [RUN_W-1:0] run_cnt;

   // Arbitrate only in IDLE and not in a done cycle: the finishing port still
   // shows its stale request, and the pipeline is advancing that cycle.
   assign arb_en = (state_q == IDLE) && !ivalid_q && !ddone_q;

   mem_arb_prio #(
      .MAX_DATA_RUN (MAX_DATA_RUN)
   ) u_prio (
      .clk       (clk),
      .reset     (reset),
      .arb_en    (arb_en),
      .instr_req (InstrReq),
      .data_req  (DataReq),
      .gnt_valid (gnt_valid),
      .gnt_sel   (gnt_sel),
      .run_cnt   (run_cnt)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid)  state_d = ISSUE;
         ISSUE:   if (mem_ready)  state_d = WAIT;
         WAIT:    if (mem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: the memory request is driven only while issuing.
   always_comb begin
      mem_valid = (state_q == ISSUE);
      mem_we    = mem_valid && we_q;
      mem_addr  = mem_valid ? addr_q  : '0;
      mem_wdata = mem_valid ? wdata_q : '0;
   end

   // Payload latch at grant, response capture and done pulse generation.
   always_comb begin
      gnt_d    = gnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      instr_d  = instr_q;
      rdata_d  = rdata_q;
      ivalid_d = 1'b0;
      ddone_d  = 1'b0;
      if (gnt_valid) begin
         gnt_d = gnt_sel;
         if (gnt_sel == GNT_D) begin
            we_d    = DataWe;
            addr_d  = DataAdr;
            wdata_d = WriteData;
         end else begin
            we_d    = 1'b0;
            addr_d  = PCF;
            wdata_d = '0;
         end
      end
      // Responses outside WAIT are stray (e.g. after a mid-transaction reset).
      if ((state_q == WAIT) && mem_rvalid) begin
         if (gnt_q == GNT_I) begin
            instr_d  = mem_rdata;
            ivalid_d = 1'b1;
         end else begin
            if (!we_q) rdata_d = mem_rdata;
            ddone_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q    <= GNT_I;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         instr_q  <= '0;
         rdata_q  <= '0;
         ivalid_q <= 1'b0;
         ddone_q  <= 1'b0;
      end else begin
         gnt_q    <= gnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         instr_q  <= instr_d;
         rdata_q  <= rdata_d;
         ivalid_q <= ivalid_d;
         ddone_q  <= ddone_d;
      end
   end

   // Port-facing results and pipeline stalls.
   always_comb begin
      InstrF     = instr_q;
      ReadData   = rdata_q;
      InstrValid = ivalid_q;
      DataDone   = ddone_q;
      StallF     = InstrReq && !ivalid_q;
      StallM     = DataReq && !ddone_q;
   end

`ifdef MEM_ARB_PERF_EN
   logic [31:0] stall_f_cnt_d, stall_f_cnt_q;
   logic [31:0] stall_m_cnt_d, stall_m_cnt_q;

   // Stall-cycle counters, free-running with wrap-around.
   always_comb begin
      stall_f_cnt_d = stall_f_cnt_q + {31'd0, StallF};
      stall_m_cnt_d = stall_m_cnt_q + {31'd0, StallM};
   end

   // Stall-cycle counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_f_cnt_q <= '0;
         stall_m_cnt_q <= '0;
      end else begin
         stall_f_cnt_q <= stall_f_cnt_d;
         stall_m_cnt_q <= stall_m_cnt_d;
      end
   end

   assign stall_f_cnt = stall_f_cnt_q;
   assign stall_m_cnt = stall_m_cnt_q;
`endif

endmodule

`default_nettype wire
